// File: rtl/fifo_arb.sv
// Round-robin arbiter that lets requesters A and B share one FIFO port.
// Each granted operation runs IDLE -> ISSUE -> RESP; every output is a flop.
module fifo_arb #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_req,
    input  logic                  b_req,
    input  logic                  a_rnw,
    input  logic                  b_rnw,
    input  logic [DATA_WIDTH-1:0] a_din,
    input  logic [DATA_WIDTH-1:0] b_din,
    input  logic                  fifo_wr_ack,
    input  logic                  fifo_wr_err,
    input  logic                  fifo_rd_ack,
    input  logic                  fifo_rd_err,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_wr_en,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  a_gnt,
    output logic                  b_gnt,
    output logic                  a_done,
    output logic                  a_err,
    output logic                  b_done,
    output logic                  b_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // ptr: last winner (1 = B); win: current winner (1 = B)
    logic ptr_q, ptr_d;
    logic win_q, win_d;
    logic rnw_q, rnw_d;

    logic a_gnt_q, a_gnt_d;
    logic b_gnt_q, b_gnt_d;
    logic a_done_q, a_done_d;
    logic a_err_q, a_err_d;
    logic b_done_q, b_done_d;
    logic b_err_q, b_err_d;
    logic wr_en_q, wr_en_d;
    logic rd_en_q, rd_en_d;

    // fifo_din_q doubles as the latched write data: it is only non-zero in ISSUE.
    logic [DATA_WIDTH-1:0] fifo_din_q, fifo_din_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic pick_b;
    logic resp_ok;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        rnw_d      = rnw_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_done_d   = 1'b0;
        a_err_d    = 1'b0;
        b_done_d   = 1'b0;
        b_err_d    = 1'b0;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        fifo_din_d = '0;
        rdata_d    = rdata_q;
        pick_b     = 1'b0;
        resp_ok    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    // B wins when alone, or on a tie when A won last time
                    pick_b  = b_req && (!a_req || !ptr_q);
                    win_d   = pick_b;
                    ptr_d   = pick_b;
                    rnw_d   = pick_b ? b_rnw : a_rnw;
                    a_gnt_d = !pick_b;
                    b_gnt_d = pick_b;
                    rd_en_d = rnw_d;
                    wr_en_d = !rnw_d;
                    if (!rnw_d) begin
                        fifo_din_d = pick_b ? b_din : a_din;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // A missing acknowledge is reported as an error
                resp_ok  = rnw_q ? fifo_rd_ack : fifo_wr_ack;
                a_done_d = !win_q && resp_ok;
                a_err_d  = !win_q && !resp_ok;
                b_done_d = win_q && resp_ok;
                b_err_d  = win_q && !resp_ok;
                if (rnw_q && resp_ok) begin
                    rdata_d = fifo_dout;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b1;
            win_q      <= 1'b0;
            rnw_q      <= 1'b0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_done_q   <= 1'b0;
            a_err_q    <= 1'b0;
            b_done_q   <= 1'b0;
            b_err_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            fifo_din_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            rnw_q      <= rnw_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_done_q   <= a_done_d;
            a_err_q    <= a_err_d;
            b_done_q   <= b_done_d;
            b_err_q    <= b_err_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            fifo_din_q <= fifo_din_d;
            rdata_q    <= rdata_d;
        end
    end

    assign fifo_wr_en = wr_en_q;
    assign fifo_rd_en = rd_en_q;
    assign fifo_din   = fifo_din_q;
    assign a_gnt      = a_gnt_q;
    assign b_gnt      = b_gnt_q;
    assign a_done     = a_done_q;
    assign a_err      = a_err_q;
    assign b_done     = b_done_q;
    assign b_err      = b_err_q;
    assign rdata      = rdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_arb.sv
// Bench for fifo_arb: directed scenarios then random traffic, all cycles checked
// against a transaction-level model and an 8-deep FIFO responder.
module tb_fifo_arb;

    localparam int W = 32;
    localparam int MODE_MODEL  = 0;
    localparam int MODE_SILENT = 1;

    logic         clk;
    logic         reset_n;
    logic         a_req, b_req, a_rnw, b_rnw;
    logic [W-1:0] a_din, b_din;
    logic         fifo_wr_ack, fifo_wr_err, fifo_rd_ack, fifo_rd_err;
    logic [W-1:0] fifo_dout;
    logic         fifo_wr_en, fifo_rd_en;
    logic [W-1:0] fifo_din;
    logic         a_gnt, b_gnt, a_done, a_err, b_done, b_err;
    logic [W-1:0] rdata;
    logic [1:0]   dbg_state;

    fifo_arb #(.DATA_WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .b_req(b_req), .a_rnw(a_rnw), .b_rnw(b_rnw),
        .a_din(a_din), .b_din(b_din),
        .fifo_wr_ack(fifo_wr_ack), .fifo_wr_err(fifo_wr_err),
        .fifo_rd_ack(fifo_rd_ack), .fifo_rd_err(fifo_rd_err),
        .fifo_dout(fifo_dout),
        .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_din(fifo_din),
        .a_gnt(a_gnt), .b_gnt(b_gnt),
        .a_done(a_done), .a_err(a_err), .b_done(b_done), .b_err(b_err),
        .rdata(rdata), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction model: phase 0 = free, 1 = granted, 2 = awaiting result
    int           m_ph;
    bit           m_last;
    bit           m_win;
    bit           m_rnw;
    logic [W-1:0] m_rdata;

    // FIFO responder: storage, pending enable seen last cycle, behaviour mode
    logic [W-1:0] fq[$];
    bit           p_wr, p_rd;
    logic [W-1:0] p_din;
    int           fifo_mode;
    bit           rnd_silent;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ctl_vec();
        return {24'd0, a_gnt, b_gnt, fifo_wr_en, fifo_rd_en, a_done, a_err, b_done, b_err};
    endfunction

    task automatic model_reset();
        m_ph        = 0;
        m_last      = 1'b1;
        m_win       = 1'b0;
        m_rnw       = 1'b0;
        m_rdata     = '0;
        p_wr        = 1'b0;
        p_rd        = 1'b0;
        p_din       = '0;
        fifo_wr_ack = 1'b0;
        fifo_wr_err = 1'b0;
        fifo_rd_ack = 1'b0;
        fifo_rd_err = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl", ctl_vec(), '0);
        check("reset_din", fifo_din, '0);
        check("reset_rdata", rdata, '0);
        check("reset_state_idle", {30'd0, dbg_state}, '0);
        reset_n = 1'b1;
    endtask

    // One clock: advance the model with the inputs sampled at this edge,
    // compare every output, then let the FIFO respond to last cycle's enable.
    task automatic step();
        logic [7:0]   e;
        logic [W-1:0] e_din;
        bit           ok;
        @(posedge clk);
        #1;
        e     = '0;
        e_din = '0;
        if (m_ph == 0) begin
            if (a_req || b_req) begin
                m_win  = (a_req && b_req) ? !m_last : !a_req;
                m_last = m_win;
                m_rnw  = m_win ? b_rnw : a_rnw;
                e[7 - m_win] = 1'b1;
                if (m_rnw) e[4] = 1'b1;
                else begin
                    e[5]  = 1'b1;
                    e_din = m_win ? b_din : a_din;
                end
                m_ph = 1;
            end
        end else if (m_ph == 1) begin
            m_ph = 2;
        end else begin
            ok = m_rnw ? fifo_rd_ack : fifo_wr_ack;
            if (!m_win) begin e[3] = ok;  e[2] = !ok; end
            else        begin e[1] = ok;  e[0] = !ok; end
            if (m_rnw && ok) m_rdata = fifo_dout;
            m_ph = 0;
        end
        check("ctl", ctl_vec(), {24'd0, e});
        check("fifo_din", fifo_din, e_din);
        check("rdata", rdata, m_rdata);

        fifo_wr_ack = 1'b0;
        fifo_wr_err = 1'b0;
        fifo_rd_ack = 1'b0;
        fifo_rd_err = 1'b0;
        fifo_dout   = $urandom;
        if (fifo_mode == MODE_MODEL && !(rnd_silent && $urandom_range(0, 9) == 0)) begin
            if (p_wr) begin
                if (fq.size() < 8) begin fq.push_back(p_din); fifo_wr_ack = 1'b1; end
                else fifo_wr_err = 1'b1;
            end
            if (p_rd) begin
                if (fq.size() > 0) begin fifo_dout = fq.pop_front(); fifo_rd_ack = 1'b1; end
                else fifo_rd_err = 1'b1;
            end
        end
        p_wr  = fifo_wr_en;
        p_rd  = fifo_rd_en;
        p_din = fifo_din;
    endtask

    task automatic run_op(input bit is_b, input bit rnw, input logic [W-1:0] din);
        if (is_b) begin b_req = 1'b1; b_rnw = rnw; b_din = din; end
        else      begin a_req = 1'b1; a_rnw = rnw; a_din = din; end
        step();
        a_req = 1'b0;
        b_req = 1'b0;
        step();
        step();
    endtask

    initial begin
        a_req = 0; b_req = 0; a_rnw = 0; b_rnw = 0; a_din = '0; b_din = '0;
        fifo_dout = '0; fifo_mode = MODE_MODEL; rnd_silent = 1'b0;
        model_reset();
        do_reset();

        // Lone A write: grant/enable/data one cycle on, done the cycle after RESP
        a_req = 1; a_rnw = 0; a_din = 32'hA5A5_0001;
        step();
        check("a_wr_gnt", {31'd0, a_gnt}, 1);
        check("a_wr_en", {31'd0, fifo_wr_en}, 1);
        check("a_wr_din", fifo_din, 32'hA5A5_0001);
        a_req = 0;
        step();
        step();
        check("a_wr_done", {31'd0, a_done}, 1);

        // Both requesting writes continuously: grants alternate starting with A
        do_reset();
        fq.delete();
        a_req = 1; b_req = 1; a_rnw = 0; b_rnw = 0; a_din = $urandom; b_din = $urandom;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 1 || i == 7) check("rr_gnt_a", {30'd0, a_gnt, b_gnt}, 2'b10);
            if (i == 4 || i == 10) check("rr_gnt_b", {30'd0, a_gnt, b_gnt}, 2'b01);
            if (a_gnt) a_din = $urandom;
            if (b_gnt) b_din = $urandom;
        end
        a_req = 0; b_req = 0;

        // B read from empty FIFO fails, then succeeds with known data
        do_reset();
        fq.delete();
        run_op(1'b1, 1'b1, '0);
        check("b_rd_empty_err", {31'd0, b_err}, 1);
        check("b_rd_empty_done", {31'd0, b_done}, 0);
        check("b_rd_empty_rdata", rdata, '0);
        fq.push_back(32'h1234_5678);
        run_op(1'b1, 1'b1, '0);
        check("b_rd_done", {31'd0, b_done}, 1);
        check("b_rd_rdata", rdata, 32'h1234_5678);

        // Nine A writes into an 8-deep FIFO: the ninth overflows
        fq.delete();
        for (int i = 0; i < 9; i++) begin
            run_op(1'b0, 1'b0, 32'h0000_0100 + i);
            check("fill_done", {31'd0, a_done}, (i < 8) ? 1 : 0);
            check("fill_err", {31'd0, a_err}, (i == 8) ? 1 : 0);
        end

        // Asynchronous reset in the middle of ISSUE
        fq.delete();
        a_req = 1; a_rnw = 0; a_din = 32'hDEAD_0031;
        step();
        a_req = 0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_ctl", ctl_vec(), '0);
        check("async_rst_din", fifo_din, '0);
        check("async_rst_rdata", rdata, '0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_hold_ctl", ctl_vec(), '0);
        reset_n = 1'b1;
        a_req = 1; b_req = 1; a_rnw = 0; b_rnw = 0; a_din = 32'h31; b_din = 32'h32;
        step();
        check("post_rst_tie_a", {30'd0, a_gnt, b_gnt}, 2'b10);
        a_req = 0;
        step();
        step();
        step();
        check("post_rst_b_gnt", {31'd0, b_gnt}, 1);
        b_req = 0;
        step();
        step();

        // No FIFO response at all is reported as an error, then IDLE at once
        fifo_mode = MODE_SILENT;
        run_op(1'b1, 1'b0, 32'h0000_0032);
        check("silent_err", {31'd0, b_err}, 1);
        check("silent_done", {31'd0, b_done}, 0);
        fifo_mode = MODE_MODEL;
        a_req = 1; a_rnw = 1;
        step();
        check("silent_then_idle", {31'd0, a_gnt}, 1);
        a_req = 0;
        step();
        step();

        // Random traffic with occasional missing responses
        fq.delete();
        rnd_silent = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (a_gnt || !a_req) begin
                a_req = ($urandom_range(0, 3) != 0);
                a_rnw = $urandom_range(0, 1);
                a_din = $urandom;
            end
            if (b_gnt || !b_req) begin
                b_req = ($urandom_range(0, 3) != 0);
                b_rnw = $urandom_range(0, 1);
                b_din = $urandom;
            end
            step();
        end
        a_req = 0; b_req = 0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
